gate_sip_security_monitor: RTL and testbench
============================================

GATE_SIP_SECURITY_MONITOR -- requirements
Module: gate_sip_security_monitor

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive high samples needed to confirm a tamper.
REQ-002 SHALL have parameter LOCK_THRESHOLD, default 3, confirmed events since last clear that force LOCKDOWN.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8 (power of two), event log depth.
REQ-004 SHALL have ports: TCK  in  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have ports: TRST_N  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports: tamper_detected  in  3  per-die tamper flags from the SiP stack (bit n = die n).
REQ-007 SHALL have ports: security_status_die0/1/2  in  8 each  per-die status bytes.
REQ-008 SHALL have ports: clear_req  in  1  single-cycle clear pulse; clear_ack  out  1  acknowledge pulse.
REQ-009 SHALL have ports: evt_valid  out  1; evt_ready  in  1; evt_data  out  26  {die_idx[25:24], status[23:16], timestamp[15:0]}.
REQ-010 SHALL have ports: die_alarm  out  3  sticky per-die alarms; mon_state  out  2  FSM state; lockdown  out  1; evt_overflow  out  1 sticky.
REQ-011 SHALL have ports: tamper_count_die0/1/2  out  8 each  saturating confirmed-event counts.

Function
REQ-012 SHALL keep a 16-bit free-running timestamp, +1 per cycle, wrapping 0xFFFF->0x0000.
REQ-013 SHALL debounce each tamper bit: per-die counter increments while input high, saturates at DEBOUNCE_CYCLES, resets to 0 on any low sample; confirmed level = counter==DEBOUNCE_CYCLES.
REQ-014 SHALL treat a 0->1 transition of a confirmed level as one event; a held-high input yields exactly one event.
REQ-015 SHALL, on an event for die n: set die_alarm[n], increment tamper_count_dien (saturate at 255), increment the 8-bit since-clear count (saturating), set pending[n] and capture {n, security_status_dien, timestamp} in that same cycle.
REQ-016 SHALL push at most one record per cycle, lowest-index pending die first; a pending record survives until pushed or dropped.
REQ-017 SHALL, when a push meets a full FIFO with no same-cycle pop, drop the record and set evt_overflow; push plus pop in same cycle on full SHALL both succeed.
REQ-018 SHALL present FIFO head on evt_data with evt_valid=!empty; pop occurs when evt_valid && evt_ready; evt_data SHALL hold stable while evt_valid && !evt_ready.
REQ-019 SHALL implement FSM NORMAL(0), ALERT(1), LOCKDOWN(2) on mon_state.
REQ-020 NORMAL->ALERT on any event; ALERT->LOCKDOWN when since-clear count >= LOCK_THRESHOLD or >=2 bits of die_alarm set; NORMAL->LOCKDOWN directly if one cycle's events already meet either condition.
REQ-021 clear_req in NORMAL or ALERT SHALL pulse clear_ack the next cycle and clear die_alarm and since-clear count, ALERT->NORMAL; FIFO, tamper counts and evt_overflow untouched.
REQ-022 clear_req in LOCKDOWN SHALL be ignored (no ack); LOCKDOWN exits only via reset.
REQ-023 Event and clear_req in same cycle: clear applies first, then the event, leaving ALERT with since-clear count 1.
REQ-024 lockdown SHALL equal (mon_state==LOCKDOWN), registered.

Reset
REQ-025 TRST_N low at a rising edge SHALL zero all outputs, counters, timestamp, debounce state, pending bits and FIFO pointers, FSM to NORMAL.
REQ-026 Reset mid-operation SHALL discard FIFO contents and pending records; no record SHALL emerge after reset release without a new event.

Structure
REQ-027 Shared package gate_sip_sec_pkg SHALL hold the FSM state encoding, record width (26) and field offsets.
REQ-028 Event FIFO SHALL be sub-module gate_sip_evt_fifo (valid/ready, full/empty, synchronous reset).

Verification
REQ-029 tamper_detected[1] high 3 cycles then low, DEBOUNCE_CYCLES=4 -> no event, die_alarm=0, mon_state=NORMAL.
REQ-030 tamper_detected[0] high 10 cycles, status_die0=0xA5 -> one record {0,0xA5,ts}, die_alarm=001, ALERT, tamper_count_die0=1.
REQ-031 bits 0 and 2 confirm same cycle -> die0 record then die2 record on consecutive pushes, LOCKDOWN next cycle, later clear_req gives no ack.
REQ-032 evt_ready=0, 9 distinct die-0 events (cleared between) -> 8 records held, evt_overflow=1, first record unchanged.
REQ-033 event in ALERT plus clear_req same cycle -> clear_ack=1 next cycle, mon_state=ALERT, since-clear count 1.
REQ-034 TRST_N low 1 cycle with 5 records queued -> evt_valid=0, all counts 0, NORMAL, timestamp restarts at 0.

Source files
------------

// File: rtl/gate_sip_sec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_sip_sec_pkg
// Brief    : Shared types, record layout and helpers for the SiP security monitor.
// Revision : 1.0
// ============================================================================
package gate_sip_sec_pkg;

  localparam int NUM_DIES       = 3;
  localparam int TS_W           = 16;
  localparam int STATUS_W       = 8;
  localparam int EVT_W          = 26;
  localparam int EVT_TS_LSB     = 0;
  localparam int EVT_STATUS_LSB = 16;
  localparam int EVT_DIE_LSB    = 24;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_ALERT    = 2'd1,
    ST_LOCKDOWN = 2'd2
  } mon_state_e;

  function automatic logic [EVT_W-1:0] make_record(
    input logic [1:0]          die,
    input logic [STATUS_W-1:0] status,
    input logic [TS_W-1:0]     ts
  );
    logic [EVT_W-1:0] r;
    r = '0;
    r[EVT_DIE_LSB +: 2]           = die;
    r[EVT_STATUS_LSB +: STATUS_W] = status;
    r[EVT_TS_LSB +: TS_W]         = ts;
    return r;
  endfunction

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_sip_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : gate_sip_evt_fifo
// Brief    : Event-record FIFO; push ignored when full unless a pop frees a slot.
// Revision : 1.0
// ============================================================================
module gate_sip_evt_fifo
  import gate_sip_sec_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = EVT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign out_data = mem_q[rd_q[AW-1:0]];

  // A pop on a full FIFO frees the head slot in time for the same-cycle write.
  always_comb begin
    do_pop  = !empty && out_ready;
    do_push = in_valid && (!full || do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gate_sip_security_monitor.sv
`default_nettype none
// ============================================================================
// Module   : gate_sip_security_monitor
// Brief    : Debounces per-die tamper flags, logs events and escalates to lockdown.
// Revision : 1.0
// ============================================================================
module gate_sip_security_monitor
  import gate_sip_sec_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCK_THRESHOLD  = 3,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic             TCK,
  input  logic             TRST_N,
  input  logic [2:0]       tamper_detected,
  input  logic [7:0]       security_status_die0,
  input  logic [7:0]       security_status_die1,
  input  logic [7:0]       security_status_die2,
  input  logic             clear_req,
  output logic             clear_ack,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [EVT_W-1:0] evt_data,
  output logic [2:0]       die_alarm,
  output logic [1:0]       mon_state,
  output logic             lockdown,
  output logic             evt_overflow,
  output logic [7:0]       tamper_count_die0,
  output logic [7:0]       tamper_count_die1,
  output logic [7:0]       tamper_count_die2
);

  localparam int               DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES);

  mon_state_e          state_q, state_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic [DEB_W-1:0]    deb_q [NUM_DIES];
  logic [DEB_W-1:0]    deb_d [NUM_DIES];
  logic [EVT_W-1:0]    rec_q [NUM_DIES];
  logic [EVT_W-1:0]    rec_d [NUM_DIES];
  logic [7:0]          tc_q  [NUM_DIES];
  logic [7:0]          tc_d  [NUM_DIES];
  logic [7:0]          status_w [NUM_DIES];
  logic [NUM_DIES-1:0] conf_w, evt_w, conf_prev_q, conf_prev_d;
  logic [NUM_DIES-1:0] pend_q, pend_d, alarm_q, alarm_d;
  logic [7:0]          sc_q, sc_d, sc_base;
  logic [8:0]          sc_sum;
  logic                push_valid;
  logic [EVT_W-1:0]    push_data;
  logic                fifo_full, fifo_empty, pop_w;
  logic                clr_w, lock_cond_w;
  logic                clear_ack_q, clear_ack_d;
  logic                lockdown_q, lockdown_d;
  logic                ovf_q, ovf_d;

  assign status_w[0] = security_status_die0;
  assign status_w[1] = security_status_die1;
  assign status_w[2] = security_status_die2;

  always_comb begin
    ts_d        = ts_q + 16'd1;
    conf_w      = '0;
    evt_w       = '0;
    for (int n = 0; n < NUM_DIES; n++) begin
      conf_w[n] = (deb_q[n] == DEB_MAX);
      evt_w[n]  = conf_w[n] && !conf_prev_q[n];
      if (!tamper_detected[n]) begin
        deb_d[n] = '0;
      end else if (conf_w[n]) begin
        deb_d[n] = deb_q[n];
      end else begin
        deb_d[n] = deb_q[n] + 1'b1;
      end
    end
    conf_prev_d = conf_w;
  end

  // Lowest pending die is pushed first; a new capture overrides the clear of a push.
  always_comb begin
    pend_d     = pend_q;
    rec_d      = rec_q;
    push_valid = 1'b0;
    push_data  = '0;
    for (int n = 0; n < NUM_DIES; n++) begin
      if (pend_q[n] && !push_valid) begin
        push_valid = 1'b1;
        push_data  = rec_q[n];
        pend_d[n]  = 1'b0;
      end
    end
    for (int n = 0; n < NUM_DIES; n++) begin
      if (evt_w[n]) begin
        pend_d[n] = 1'b1;
        rec_d[n]  = make_record(2'(n), status_w[n], ts_q);
      end
    end
  end

  // Clear takes effect before same-cycle events are accounted.
  always_comb begin
    clr_w       = clear_req && (state_q != ST_LOCKDOWN);
    alarm_d     = (clr_w ? '0 : alarm_q) | evt_w;
    sc_base     = clr_w ? 8'd0 : sc_q;
    sc_sum      = {1'b0, sc_base} + {7'd0, popcount3(evt_w)};
    sc_d        = sc_sum[8] ? 8'hFF : sc_sum[7:0];
    for (int n = 0; n < NUM_DIES; n++) begin
      tc_d[n] = (evt_w[n] && tc_q[n] != 8'hFF) ? tc_q[n] + 8'd1 : tc_q[n];
    end
    lock_cond_w = (int'(sc_d) >= LOCK_THRESHOLD) || (popcount3(alarm_d) >= 2'd2);
    state_d     = state_q;
    if (state_q != ST_LOCKDOWN) begin
      if (|evt_w) begin
        state_d = lock_cond_w ? ST_LOCKDOWN : ST_ALERT;
      end else if (clr_w) begin
        state_d = ST_NORMAL;
      end
    end
    clear_ack_d = clr_w;
    lockdown_d  = (state_d == ST_LOCKDOWN);
    ovf_d       = ovf_q || (push_valid && fifo_full && !pop_w);
  end

  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      state_q     <= ST_NORMAL;
      ts_q        <= '0;
      conf_prev_q <= '0;
      pend_q      <= '0;
      alarm_q     <= '0;
      sc_q        <= '0;
      clear_ack_q <= 1'b0;
      lockdown_q  <= 1'b0;
      ovf_q       <= 1'b0;
      for (int n = 0; n < NUM_DIES; n++) begin
        deb_q[n] <= '0;
        rec_q[n] <= '0;
        tc_q[n]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_d;
      conf_prev_q <= conf_prev_d;
      pend_q      <= pend_d;
      alarm_q     <= alarm_d;
      sc_q        <= sc_d;
      clear_ack_q <= clear_ack_d;
      lockdown_q  <= lockdown_d;
      ovf_q       <= ovf_d;
      deb_q       <= deb_d;
      rec_q       <= rec_d;
      tc_q        <= tc_d;
    end
  end

  gate_sip_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_evt_fifo (
    .clk       (TCK),
    .rst_n     (TRST_N),
    .in_valid  (push_valid),
    .in_data   (push_data),
    .out_ready (evt_ready),
    .out_data  (evt_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign evt_valid         = !fifo_empty;
  assign pop_w             = evt_valid && evt_ready;
  assign clear_ack         = clear_ack_q;
  assign die_alarm         = alarm_q;
  assign mon_state         = state_q;
  assign lockdown          = lockdown_q;
  assign evt_overflow      = ovf_q;
  assign tamper_count_die0 = tc_q[0];
  assign tamper_count_die1 = tc_q[1];
  assign tamper_count_die2 = tc_q[2];

endmodule
`default_nettype wire

// File: tb/tb_gate_sip_security_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_sip_security_monitor
// Brief    : Directed self-checking bench for the SiP security monitor.
// Revision : 1.0
// ============================================================================
module tb_gate_sip_security_monitor;

  logic        TCK = 1'b0;
  logic        TRST_N = 1'b0;
  logic [2:0]  tamper_detected = '0;
  logic [7:0]  status0 = '0, status1 = '0, status2 = '0;
  logic        clear_req = 1'b0;
  logic        clear_ack;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [25:0] evt_data;
  logic [2:0]  die_alarm;
  logic [1:0]  mon_state;
  logic        lockdown;
  logic        evt_overflow;
  logic [7:0]  tc0, tc1, tc2;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] ts_m;
  logic [15:0] t0;
  logic [25:0] first_rec, second_rec;

  gate_sip_security_monitor #(
    .DEBOUNCE_CYCLES (4),
    .LOCK_THRESHOLD  (3),
    .FIFO_DEPTH      (8)
  ) dut (
    .TCK                  (TCK),
    .TRST_N               (TRST_N),
    .tamper_detected      (tamper_detected),
    .security_status_die0 (status0),
    .security_status_die1 (status1),
    .security_status_die2 (status2),
    .clear_req            (clear_req),
    .clear_ack            (clear_ack),
    .evt_valid            (evt_valid),
    .evt_ready            (evt_ready),
    .evt_data             (evt_data),
    .die_alarm            (die_alarm),
    .mon_state            (mon_state),
    .lockdown             (lockdown),
    .evt_overflow         (evt_overflow),
    .tamper_count_die0    (tc0),
    .tamper_count_die1    (tc1),
    .tamper_count_die2    (tc2)
  );

  always #5 TCK = ~TCK;

  // Reference timestamp: zero on a reset edge, +1 on every other edge.
  always @(posedge TCK) begin
    if (!TRST_N) ts_m <= 16'd0;
    else         ts_m <= ts_m + 16'd1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge TCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] rec(input logic [1:0] die, input logic [7:0] st, input logic [15:0] ts);
    return {die, st, ts};
  endfunction

  task automatic do_clear();
    clear_req = 1'b1;
    step(1);
    clear_req = 1'b0;
  endtask

  initial begin
    TRST_N = 1'b0;
    step(2);
    TRST_N = 1'b1;
    check("rst_valid", evt_valid, 0);
    check("rst_alarm", die_alarm, 0);
    check("rst_state", mon_state, 0);
    check("rst_lockdown", lockdown, 0);
    check("rst_ovf", evt_overflow, 0);
    check("rst_ack", clear_ack, 0);
    check("rst_counts", {8'd0, tc0, tc1, tc2}, 0);

    // Glitch shorter than the debounce window
    tamper_detected = 3'b010;
    step(3);
    tamper_detected = 3'b000;
    step(6);
    check("short_alarm", die_alarm, 0);
    check("short_state", mon_state, 0);
    check("short_valid", evt_valid, 0);
    check("short_tc1", tc1, 0);

    // Held-high die 0: exactly one record
    status0 = 8'hA5;
    tamper_detected = 3'b001;
    t0 = ts_m;
    step(10);
    check("d0_valid", evt_valid, 1);
    check("d0_data", evt_data, rec(2'd0, 8'hA5, t0 + 16'd4));
    check("d0_alarm", die_alarm, 3'b001);
    check("d0_state", mon_state, 1);
    check("d0_tc0", tc0, 1);
    tamper_detected = 3'b000;
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("d0_single_rec", evt_valid, 0);
    do_clear();
    check("clr_ack", clear_ack, 1);
    check("clr_state", mon_state, 0);
    check("clr_alarm", die_alarm, 0);
    step(1);
    check("clr_ack_pulse", clear_ack, 0);

    // Dies 0 and 2 confirm together
    status0 = 8'h11;
    status2 = 8'h22;
    tamper_detected = 3'b101;
    t0 = ts_m;
    step(4);
    check("dual_pre_state", mon_state, 0);
    step(1);
    check("dual_state", mon_state, 2);
    check("dual_lockdown", lockdown, 1);
    check("dual_alarm", die_alarm, 3'b101);
    check("dual_not_pushed", evt_valid, 0);
    step(1);
    check("dual_first_valid", evt_valid, 1);
    check("dual_first", evt_data, rec(2'd0, 8'h11, t0 + 16'd4));
    step(1);
    evt_ready = 1'b1;
    step(1);
    check("dual_second_valid", evt_valid, 1);
    check("dual_second", evt_data, rec(2'd2, 8'h22, t0 + 16'd4));
    step(1);
    evt_ready = 1'b0;
    check("dual_drained", evt_valid, 0);
    tamper_detected = 3'b000;
    do_clear();
    check("lock_no_ack", clear_ack, 0);
    check("lock_hold", mon_state, 2);
    step(1);
    check("lock_no_ack2", clear_ack, 0);
    check("lock_tc", {tc0, tc2}, {8'd2, 8'd1});

    TRST_N = 1'b0;
    step(1);
    TRST_N = 1'b1;
    check("rst2_state", mon_state, 0);
    check("rst2_tc", {tc0, tc2}, 0);

    // Overflow: nine die-0 events, nothing popped
    evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      status0 = 8'h30 + 8'(i);
      tamper_detected = 3'b001;
      t0 = ts_m;
      step(5);
      tamper_detected = 3'b000;
      step(3);
      if (i == 0) first_rec = rec(2'd0, 8'h30, t0 + 16'd4);
      if (i == 1) second_rec = rec(2'd0, 8'h31, t0 + 16'd4);
      do_clear();
      step(1);
      if (i == 7) check("ovf_not_at_8", evt_overflow, 0);
    end
    check("ovf_set", evt_overflow, 1);
    check("ovf_valid", evt_valid, 1);
    check("ovf_head", evt_data, first_rec);
    check("ovf_tc0", tc0, 9);
    check("ovf_state", mon_state, 0);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("ovf_second", evt_data, second_rec);
    evt_ready = 1'b1;
    step(2);
    evt_ready = 1'b0;
    check("q5_valid", evt_valid, 1);

    // Mid-operation reset with records queued
    TRST_N = 1'b0;
    step(1);
    TRST_N = 1'b1;
    check("rst3_valid", evt_valid, 0);
    check("rst3_ovf", evt_overflow, 0);
    check("rst3_tc0", tc0, 0);
    check("rst3_state", mon_state, 0);
    status0 = 8'h5A;
    tamper_detected = 3'b001;
    step(1);
    check("rst3_no_stale", evt_valid, 0);
    step(4);
    check("rst3_pending_only", evt_valid, 0);
    tamper_detected = 3'b000;
    step(2);
    check("rst3_ts_restart", evt_data, rec(2'd0, 8'h5A, 16'd4));

    // Event and clear in the same cycle while in ALERT
    evt_ready = 1'b1;
    status1 = 8'h77;
    tamper_detected = 3'b010;
    step(4);
    clear_req = 1'b1;
    step(1);
    clear_req = 1'b0;
    check("ec_ack", clear_ack, 1);
    check("ec_state", mon_state, 1);
    check("ec_alarm", die_alarm, 3'b010);
    tamper_detected = 3'b000;
    step(2);
    tamper_detected = 3'b010;
    step(5);
    tamper_detected = 3'b000;
    step(2);
    check("ec_sc2_alert", mon_state, 1);
    tamper_detected = 3'b010;
    step(5);
    tamper_detected = 3'b000;
    step(1);
    check("ec_sc3_lock", mon_state, 2);
    check("ec_lockdown", lockdown, 1);
    check("ec_tc1", tc1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
